// File: rtl/sha_msg_pkg.sv
// rtl/sha_msg_pkg.sv - shared states, constants and block-count helper for sha_msg_packer
package sha_msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam logic [7:0] SYNC_DEF     = 8'hA5;
  localparam int         NBLK_MAX_DEF = 2;
  localparam int         BLK_BYTES    = 64;
  localparam int         LENF_BYTES   = 8;

  // Blocks needed for L payload bytes plus the 0x80 marker and the length field.
  function automatic logic [1:0] nblk_of(input logic [6:0] len);
    int n;
    n = (int'(len) + LENF_BYTES + 1 + BLK_BYTES - 1) / BLK_BYTES;
    return 2'(n);
  endfunction

endpackage

// File: rtl/sha_pad_byte.sv
// rtl/sha_pad_byte.sv - combinational SHA-256 padding byte for buffer index idx
module sha_pad_byte (
  input  logic [6:0] idx_i,
  input  logic [6:0] len_i,
  input  logic [1:0] nblk_i,
  output logic [7:0] byte_o
);

  logic [7:0] last_idx;
  logic [9:0] bit_len;

  always_comb begin
    last_idx = {nblk_i, 6'd0} - 8'd1;
    bit_len  = {len_i, 3'd0};
    byte_o   = 8'h00;
    if (idx_i == len_i)
      byte_o = 8'h80;
    else if ({1'b0, idx_i} == last_idx)
      byte_o = bit_len[7:0];
    else if ({1'b0, idx_i} == last_idx - 8'd1)
      byte_o = {6'd0, bit_len[9:8]};
  end

endmodule

// File: rtl/sha_msg_packer.sv
// rtl/sha_msg_packer.sv - frames UART bytes into a padded 1/2-block SHA-256 image
// Optional checksum byte after the payload: define SHA_MSG_PACKER_CSUM_EN.
module sha_msg_packer
  import sha_msg_pkg::*;
#(
  parameter logic [7:0] SYNC     = SYNC_DEF,
  parameter int         NBLK_MAX = NBLK_MAX_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  input  logic                    msg_ready_i,
  output logic [512*NBLK_MAX-1:0] msg_o,
  output logic [1:0]              nblk_o,
  output logic [6:0]              len_o,
  output logic                    msg_valid_o,
  output logic                    err_o,
  output logic                    drop_o
);

  localparam int BUF_BYTES = BLK_BYTES * NBLK_MAX;
  localparam int MAX_LEN   = BUF_BYTES - LENF_BYTES - 1;
  localparam int MSG_W     = 512 * NBLK_MAX;

  state_e     state_q;
  logic [7:0] mem_q [BUF_BYTES];
  logic [6:0] idx_q;
  logic [6:0] len_q;
  logic [1:0] nblk_q;
  logic       valid_q;
  logic       err_q;
  logic       drop_q;
  logic [7:0] pad_byte;
  logic [6:0] last_idx;
`ifdef SHA_MSG_PACKER_CSUM_EN
  logic [7:0] xor_q;
`endif

  assign last_idx = 7'({nblk_q, 6'd0} - 8'd1);

  sha_pad_byte u_pad (
    .idx_i  (idx_q),
    .len_i  (len_q),
    .nblk_i (nblk_q),
    .byte_o (pad_byte)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      nblk_q  <= 2'd1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      for (int k = 0; k < BUF_BYTES; k++) mem_q[k] <= '0;
`ifdef SHA_MSG_PACKER_CSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i && data_i == SYNC) begin
            state_q <= ST_LEN;
            idx_q   <= '0;
            for (int k = 0; k < BUF_BYTES; k++) mem_q[k] <= '0;
`ifdef SHA_MSG_PACKER_CSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (valid_i) begin
            if (data_i > 8'(MAX_LEN)) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              len_q  <= data_i[6:0];
              nblk_q <= nblk_of(data_i[6:0]);
              if (data_i != 8'd0)
                state_q <= ST_PAYLOAD;
`ifdef SHA_MSG_PACKER_CSUM_EN
              else
                state_q <= ST_CSUM;
`else
              else
                state_q <= ST_PAD;
`endif
            end
          end
        end
        ST_PAYLOAD: begin
          if (valid_i) begin
            mem_q[idx_q] <= data_i;
            idx_q        <= idx_q + 7'd1;
`ifdef SHA_MSG_PACKER_CSUM_EN
            xor_q        <= xor_q ^ data_i;
            if (idx_q == len_q - 7'd1) state_q <= ST_CSUM;
`else
            if (idx_q == len_q - 7'd1) state_q <= ST_PAD;
`endif
          end
        end
`ifdef SHA_MSG_PACKER_CSUM_EN
        ST_CSUM: begin
          if (valid_i) begin
            if (data_i == xor_q) begin
              state_q <= ST_PAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_PAD: begin
          // idx_q already sits at L when PAD is entered
          drop_q       <= valid_i;
          mem_q[idx_q] <= pad_byte;
          idx_q        <= idx_q + 7'd1;
          if (idx_q == last_idx) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          drop_q <= valid_i;
          if (msg_ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < BUF_BYTES; k++) begin : g_flat
    assign msg_o[MSG_W-1-8*k -: 8] = mem_q[k];
  end

  assign nblk_o      = nblk_q;
  assign len_o       = len_q;
  assign msg_valid_o = valid_q;
  assign err_o       = err_q;
  assign drop_o      = drop_q;

endmodule

// File: doc/sha_msg_packer.md
# sha_msg_packer

Upstream stage of the mining core: it takes the byte stream from the UART receiver and frames it as sync, length, payload and (optionally) checksum. It applies standard SHA-256 padding and presents a complete 1- or 2-block big-endian message image (up to 128 bytes) with a valid/ready handshake. The consumer loads this image as its word array: word 0 is bytes 0..3, MSB first.

## Interface
- `SYNC`, 8'hA5, frame start byte.
- `NBLK_MAX`, 2, maximum 512-bit blocks. Buffer is 64*NBLK_MAX bytes. `MAX_LEN` = 64*NBLK_MAX-9 (119 by default).
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `data_i`  in  8  received byte, valid only with `valid_i`.
- `valid_i`  in  1  one-cycle byte strobe from the UART.
- `msg_ready_i`  in  1  consumer accepts the message image.
- `msg_o`  out  512*NBLK_MAX  padded message. Byte k is at bits [1023-8k -: 8].
- `nblk_o`  out  2  number of blocks in `msg_o` (1 or 2).
- `len_o`  out  7  payload length L in bytes.
- `msg_valid_o`  out  1  level; image stable while high.
- `err_o`  out  1  one-cycle pulse: bad length or checksum mismatch.
- `drop_o`  out  1  one-cycle pulse: a byte arrived while the block was busy and was discarded.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, PAD, DONE.
- **IDLE**
  - `valid_i` && `data_i`==SYNC: go to LEN and zero the whole buffer.
  - Any other byte is ignored silently.
- **LEN**
  - On `valid_i`, latch L = `data_i`.
  - L > MAX_LEN: pulse `err_o`, go to IDLE.
  - L==0: go to CSUM (if enabled) or PAD.
  - Otherwise go to PAYLOAD.
  - nblk = 1 if L ≤ 55, else 2.
- **PAYLOAD**
  - Each `valid_i` byte is written at index idx, then idx increments.
  - Running XOR of the payload is kept.
  - After byte L-1, go to CSUM or PAD.
- **CSUM** (present only with the macro)
  - The next byte is compared with the running XOR.
  - Match: go to PAD.
  - Mismatch: pulse `err_o`, go to IDLE; `msg_valid_o` is never raised.
- **PAD**: writes one byte per cycle over indices L .. 64*nblk-1, without waiting for `valid_i`.
  - Index L gets 8'h80.
  - Index 64*nblk-2 gets (L*8)>>8; index 64*nblk-1 gets (L*8)&8'hFF.
  - All other indices get 8'h00.
  - The 64-bit bit length is big-endian; its upper 6 bytes are always 0.
- **DONE**
  - `msg_valid_o`=1; `msg_o`, `nblk_o` and `len_o` are frozen.
  - `msg_ready_i`=1: go to IDLE and drop `msg_valid_o` the next cycle. `msg_o` holds its value until the next SYNC clears it.
- Drop rule: a `valid_i` in PAD or DONE is discarded and pulses `drop_o`. This includes a byte arriving in the same cycle as the DONE→IDLE handshake.
- Length byte and payload bytes may equal SYNC; there is no resync inside a frame.
- `rst_i` at any point, including mid-frame, takes effect at the next edge:
  - state goes to IDLE and the buffer to 0;
  - all outputs go to 0, and `nblk_o` goes to 1.

## Timing
- Cycle t is the edge that accepts the last payload byte (or the checksum byte with the macro). For L=0 it is the length byte (without the macro) or the checksum byte.
- PAD occupies cycles t+1 .. t+P, where P = 64*nblk - L.
- `msg_valid_o` rises at t+P+1.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `err_o` is asserted in the cycle after the offending byte is sampled.
- `drop_o` is asserted in the cycle after the discarded byte is sampled.
- Input bytes may arrive back-to-back, one per cycle.

## Configuration
- `SHA_MSG_PACKER_CSUM_EN` defined: the CSUM state exists and one XOR checksum byte follows the payload. For L=0 the expected checksum is 8'h00.
- Not defined: no CSUM state and no XOR register; PAYLOAD/LEN go directly to PAD; `err_o` flags length errors only.

## Structure
- Package `sha_msg_pkg` holds:
  - the state enum;
  - the SYNC default;
  - localparams for block bytes (64) and length-field bytes (8);
  - function `nblk_of(L)`.
- Sub-module `sha_pad_byte`: combinational, (idx, L, nblk) → pad byte. It is instantiated once and feeds the PAD write port.
- Byte buffer is a register array; `msg_o` is its flat concatenation.

## Test plan
- **"abc" single block:** A5,03,61,62,63 (plus checksum 60 with the macro).
  - Response: word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018, nblk_o=1.
  - `msg_valid_o` rises 62 cycles after the last accepted byte.
- **Two-block frame:** L=56 of 0x00.
  - Response: byte 56 = 0x80, word31 = 0x000001C0, nblk_o=2, valid 73 cycles after the last byte.
- **Length error:** A5,0x78.
  - Response: `err_o` pulse, state IDLE; a following A5,00 completes with word0 = 0x80000000, word15 = 0.
- **Checksum mismatch (macro on):** A5,02,11,22,00.
  - Response: `err_o` pulse, no `msg_valid_o`; the same frame with checksum 33 succeeds.
- **Backpressure:** hold `msg_ready_i`=0 and send A5 in DONE.
  - Response: `drop_o` pulse, image unchanged; a later `msg_ready_i` drops valid the next cycle.
- **Reset mid-frame:** `rst_i` during PAYLOAD after 10 bytes.
  - Response: all outputs 0, nblk_o=1; a new full frame then completes normally.
